// File: rtl/ysyx_22051013_cache_data_array_pkg.sv
// Shared definitions for the L1 cache data array: FSM state encoding and the
// width helpers used to size ports from the WAYS/SETS/DATA_W parameters.
package ysyx_22051013_cache_data_array_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // A single-way array still carries a 1-bit way select so the port never vanishes.
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ysyx_22051013_cache_data_array_if.sv
// Request/response bundle between the cache FSM (master) and the data array (slave).
interface ysyx_22051013_cache_data_array_if
  import ysyx_22051013_cache_data_array_pkg::*;
#(
  parameter int WAYS   = 4,
  parameter int SETS   = 32,
  parameter int DATA_W = 64
);
  localparam int IDX_W  = idx_w(SETS);
  localparam int WAY_W  = way_w(WAYS);
  localparam int STRB_W = strb_w(DATA_W);

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [IDX_W-1:0]       req_index;
  logic [WAY_W-1:0]       req_way;
  logic [STRB_W-1:0]      wr_strb;
  logic [DATA_W-1:0]      wr_data;
  logic                   rd_valid;
  logic [WAYS*DATA_W-1:0] rd_data;
  logic                   clear_req;
  logic                   busy;

  modport master (
    output req_valid, req_write, req_index, req_way, wr_strb, wr_data, clear_req,
    input  req_ready, rd_valid, rd_data, busy
  );

  modport slave (
    input  req_valid, req_write, req_index, req_way, wr_strb, wr_data, clear_req,
    output req_ready, rd_valid, rd_data, busy
  );

endinterface

// File: rtl/ysyx_22051013_cache_data_bank.sv
// One way of the data array: SETS x DATA_W storage with byte-strobe write and
// a registered synchronous read port.
module ysyx_22051013_cache_data_bank
  import ysyx_22051013_cache_data_array_pkg::*;
#(
  parameter int SETS   = 32,
  parameter int DATA_W = 64,
  localparam int IDX_W  = idx_w(SETS),
  localparam int STRB_W = strb_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [SETS];

  // NOTE: the storage has no reset so it maps onto RAM macros; contents are
  // defined only after a clear sweep or an explicit write.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read register holds its value between reads; a read racing a write to
  // the same set returns the pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ysyx_22051013_cache_data_array.sv
// Multi-way L1 cache data array: parallel all-way reads, per-way strobed writes,
// and a clear sequencer that zeroes every set after reset or on request.
module ysyx_22051013_cache_data_array
  import ysyx_22051013_cache_data_array_pkg::*;
#(
  parameter int WAYS           = 4,
  parameter int SETS           = 32,
  parameter int DATA_W         = 64,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic                             clk,
  input logic                             rst_n,
  ysyx_22051013_cache_data_array_if.slave bus
);

  localparam int IDX_W  = idx_w(SETS);
  localparam int WAY_W  = way_w(WAYS);
  localparam int STRB_W = strb_w(DATA_W);
  localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  sweep_cnt_q;
  logic              sweep, accept, rd_en, wr_en;
  logic [IDX_W-1:0]  bank_index;
  logic [STRB_W-1:0] bank_strb;
  logic [DATA_W-1:0] bank_data;
  logic [DATA_W-1:0] rd_word [WAYS];

  // NOTE: every variable is given a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR: if (sweep_cnt_q == IDX_W'(SETS - 1)) state_d = ST_READY;
      ST_READY: if (bus.clear_req)                   state_d = ST_CLEAR;
      default:                                       state_d = RESET_STATE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      sweep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      // Wraps from SETS-1 back to 0 exactly as the sweep ends (SETS is a power of two).
      sweep_cnt_q <= (state_q == ST_CLEAR) ? sweep_cnt_q + IDX_W'(1) : '0;
    end
  end

  assign sweep         = (state_q == ST_CLEAR);
  assign bus.busy      = sweep;
  // Combinational from clear_req so a clear request wins over a same-cycle access.
  assign bus.req_ready = (state_q == ST_READY) && !bus.clear_req;
  assign accept        = bus.req_valid && bus.req_ready;
  assign rd_en         = accept && !bus.req_write;
  assign wr_en         = accept &&  bus.req_write;

  assign bank_index = sweep ? sweep_cnt_q : bus.req_index;
  assign bank_strb  = sweep ? '1 : bus.wr_strb;
  assign bank_data  = sweep ? '0 : bus.wr_data;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic bank_we;
    assign bank_we = sweep || (wr_en && (bus.req_way == WAY_W'(w)));

    ysyx_22051013_cache_data_bank #(
      .SETS   (SETS),
      .DATA_W (DATA_W)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bank_we),
      .waddr (bank_index),
      .wstrb (bank_strb),
      .wdata (bank_data),
      .re    (rd_en),
      .raddr (bus.req_index),
      .rdata (rd_word[w])
    );
  end

  always_comb begin
    bus.rd_data = '0;
    for (int w = 0; w < WAYS; w++) bus.rd_data[w*DATA_W +: DATA_W] = rd_word[w];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.rd_valid <= 1'b0;
    else        bus.rd_valid <= rd_en;
  end

endmodule

// File: tb/tb_ysyx_22051013_cache_data_array.sv
// Directed bench for the cache data array: reset sweep, strobed writes,
// back-to-back reads, clear requests and reset during a sweep.
module tb_ysyx_22051013_cache_data_array;

  localparam int WAYS   = 4;
  localparam int SETS   = 32;
  localparam int DATA_W = 64;
  localparam int LIMIT  = 100;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ysyx_22051013_cache_data_array_if #(
    .WAYS(WAYS), .SETS(SETS), .DATA_W(DATA_W)
  ) bus ();

  ysyx_22051013_cache_data_array #(
    .WAYS(WAYS), .SETS(SETS), .DATA_W(DATA_W), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WAYS*DATA_W-1:0] ways4(input logic [63:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_index = '0;
    bus.req_way   = '0;
    bus.wr_strb   = '0;
    bus.wr_data   = '0;
    bus.clear_req = 1'b0;
  endtask

  task automatic do_write(input int way, input int idx, input logic [63:0] data,
                          input logic [7:0] strb);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_way   = 2'(way);
    bus.req_index = 5'(idx);
    bus.wr_data   = data;
    bus.wr_strb   = strb;
    tick();
    idle_bus();
  endtask

  task automatic do_read(input int idx);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_index = 5'(idx);
    tick();
    idle_bus();
  endtask

  // Counts busy cycles from now until READY, bounded by LIMIT.
  task automatic wait_sweep(output int n);
    n = 0;
    while (bus.busy && n < LIMIT) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    idle_bus();
    repeat (3) tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b req_ready=%b, expected busy=1 req_ready=0", bus.busy, bus.req_ready);
    end
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
      errors++;
      $display("FAIL reset_rd: rd_valid=%b rd_data=%h, expected 0 and 0", bus.rd_valid, bus.rd_data);
    end
    rst_n = 1'b1;
    wait_sweep(n);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL reset_sweep_len: busy for %0d cycles, expected 32", n);
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b, expected 1", bus.req_ready);
    end
    do_read(31);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== '0) begin
      errors++;
      $display("FAIL read_idx31: rd_valid=%b rd_data=%h, expected 1 and 0", bus.rd_valid, bus.rd_data);
    end
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_valid_pulse: rd_valid=%b, expected 0", bus.rd_valid);
    end
  endtask

  task automatic test_write();
    logic [WAYS*DATA_W-1:0] exp;
    do_write(2, 5, 64'h1122334455667788, 8'hFF);
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_no_rd_valid: rd_valid=%b, expected 0", bus.rd_valid);
    end
    do_read(5);
    exp = ways4(64'h0, 64'h0, 64'h1122334455667788, 64'h0);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
      errors++;
      $display("FAIL full_write: rd_valid=%b rd_data=%h, expected 1 and %h", bus.rd_valid, bus.rd_data, exp);
    end
  endtask

  task automatic test_partial_write();
    logic [WAYS*DATA_W-1:0] exp;
    exp = ways4(64'h0, 64'h0, 64'h11223344AAAAAAAA, 64'h0);
    do_write(2, 5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    do_read(5);
    checks++;
    if (bus.rd_data !== exp) begin
      errors++;
      $display("FAIL partial_write: rd_data=%h, expected %h", bus.rd_data, exp);
    end
    do_write(2, 5, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    do_read(5);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
      errors++;
      $display("FAIL zero_strobe: rd_valid=%b rd_data=%h, expected 1 and %h", bus.rd_valid, bus.rd_data, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [WAYS*DATA_W-1:0] exp [3];
    int bad;
    do_write(0, 3, 64'h0303030303030303, 8'hFF);
    do_write(1, 4, 64'h0404040404040404, 8'hFF);
    exp[0] = ways4(64'h0303030303030303, 64'h0, 64'h0, 64'h0);
    exp[1] = ways4(64'h0, 64'h0404040404040404, 64'h0, 64'h0);
    exp[2] = ways4(64'h0, 64'h0, 64'h11223344AAAAAAAA, 64'h0);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.req_index = 5'(3 + i);
      tick();
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp[i]) begin
        errors++;
        $display("FAIL b2b_read_%0d: rd_valid=%b rd_data=%h, expected 1 and %h", 3 + i, bus.rd_valid, bus.rd_data, exp[i]);
      end
    end
    idle_bus();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      do_write(3, 10 + i, 64'hDEADBEEF00000000 | 64'(i), 8'hFF);
      if (bus.rd_valid !== 1'b0 || bus.rd_data !== exp[2]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rd_data_hold: %0d of 10 cycles wrong, last rd_valid=%b rd_data=%h, expected 0 and %h", bad, bus.rd_valid, bus.rd_data, exp[2]);
    end
  endtask

  task automatic test_clear();
    int n;
    logic [WAYS*DATA_W-1:0] held;
    held = ways4(64'h0, 64'h0, 64'h11223344AAAAAAAA, 64'h0);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_index = 5'd5;
    bus.clear_req = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_blocks_ready: req_ready=%b, expected 0", bus.req_ready);
    end
    tick();
    idle_bus();
    checks++;
    if (bus.busy !== 1'b1 || bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_start: busy=%b rd_valid=%b, expected busy=1 rd_valid=0", bus.busy, bus.rd_valid);
    end
    wait_sweep(n);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL clear_sweep_len: busy for %0d cycles, expected 32", n);
    end
    checks++;
    if (bus.rd_data !== held) begin
      errors++;
      $display("FAIL clear_keeps_rd_data: rd_data=%h, expected %h", bus.rd_data, held);
    end
    do_read(5);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== '0) begin
      errors++;
      $display("FAIL clear_idx5: rd_valid=%b rd_data=%h, expected 1 and 0", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    logic [WAYS*DATA_W-1:0] exp;
    exp = ways4(64'h0, 64'hCAFEF00D12345678, 64'h0, 64'h0);
    do_write(1, 7, 64'hCAFEF00D12345678, 8'hFF);
    do_read(7);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
      errors++;
      $display("FAIL pre_reset_read: rd_valid=%b rd_data=%h, expected 1 and %h", bus.rd_valid, bus.rd_data, exp);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== '0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_drops_read: rd_valid=%b rd_data=%h busy=%b, expected 0, 0, 1", bus.rd_valid, bus.rd_data, bus.busy);
    end
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_sweep_busy: busy=%b, expected 1", bus.busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_sweep(n);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL restart_sweep_len: busy for %0d cycles, expected 32", n);
    end
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_ready: rd_valid=%b req_ready=%b, expected 0 and 1", bus.rd_valid, bus.req_ready);
    end
    do_read(7);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== '0) begin
      errors++;
      $display("FAIL restart_idx7: rd_valid=%b rd_data=%h, expected 1 and 0", bus.rd_valid, bus.rd_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write();
    test_partial_write();
    test_back_to_back();
    test_clear();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22051013_cache_data_array.md
# ysyx_22051013_cache_data_array

Parametrised, multi-way data array for the pipelined CPU's L1 caches, succeeding the single-way 32x64 data RAM. Each read returns all ways of a set in parallel for hit selection; each write updates one way under a per-byte strobe mask. A built-in clear sequencer zeroes the array after reset and on request, with a valid/ready request port that stalls the cache FSM while the array is busy.

## Interface
Parameters:
- WAYS, 4: number of ways; power of two, at least 1.
- SETS, 32: sets per way; power of two, at least 2; IDX_W = log2(SETS).
- DATA_W, 64: bits per entry; multiple of 8; STRB_W = DATA_W/8.
- CLEAR_ON_RESET, 1: 1 = run a clear sweep after reset; 0 = ready immediately.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_index  in  IDX_W  set index.
- req_way  in  max(1,log2(WAYS))  target way; writes only.
- wr_strb  in  STRB_W  byte enables; bit i enables wr_data[8i+7:8i].
- wr_data  in  DATA_W  write data.
- rd_valid  out  1  one-cycle pulse: rd_data holds the result of the read accepted in the previous cycle.
- rd_data  out  WAYS*DATA_W  way w occupies bits [w*DATA_W +: DATA_W].
- clear_req  in  1  start a clear sweep; sampled only in READY.
- busy  out  1  clear sweep in progress.

## Operation
- States: CLEAR and READY.
- On reset: enter CLEAR if CLEAR_ON_RESET=1, otherwise READY. Sweep counter is set to 0.
- CLEAR state:
  - Each cycle, write zero to every way at index = counter, then increment the counter.
  - When the counter reaches SETS-1, that set is written and the next state is READY.
  - busy=1 and req_ready=0 throughout; clear_req is ignored.
- READY state:
  - busy=0.
  - req_ready = !clear_req. This is a combinational path from clear_req, and it is intentional.
  - If clear_req=1: go to CLEAR with the counter at 0. No request is accepted that cycle.
- Accepted read: all WAYS entries at req_index are registered into rd_data, and rd_valid pulses on the next cycle.
- Accepted write: only bytes with wr_strb=1 in way req_way at req_index are updated. wr_strb=0 is a legal no-op write. Writes never pulse rd_valid.
- rd_data holds its last value until the next accepted read; it is not cleared by writes or by a sweep. The reset value is 0.
- Storage contents are not affected by rst_n. The array holds undefined data until a sweep completes, or, with CLEAR_ON_RESET=0, until written.
- Reset asserted mid-sweep: the sweep aborts. On release the sweep restarts from index 0 (if CLEAR_ON_RESET=1).
- Reset asserted while a read is in flight: rd_valid=0 and rd_data=0; the pending result is dropped.

## Timing
- Read latency is 1 cycle: a request accepted at edge N gives rd_valid=1 and rd_data valid after edge N+1.
- Back-to-back reads at full rate are supported.
- A write accepted at edge N is visible to a read accepted at edge N+1.
- Sweep length is exactly SETS cycles. For SETS=32 with CLEAR_ON_RESET=1, req_ready first rises in cycle 33 after reset release.
- Reset values: req_ready = !CLEAR_ON_RESET, busy = CLEAR_ON_RESET, rd_valid=0, rd_data=0.

## Structure
- Shared package/header holds the state encoding (CLEAR=1'b0, READY=1'b1) and the width helpers IDX_W, WAY_W, STRB_W.
- Sub-module ysyx_22051013_cache_data_bank is instantiated WAYS times. Each instance is a SETS x DATA_W synchronous-read bank with:
  - byte-strobe write;
  - an independent read register.
- The top level holds:
  - the FSM;
  - the sweep counter;
  - per-way write-enable decode (sweep forces all ways with a full strobe and zero data);
  - rd_valid generation.

## Test plan
- Reset release, WAYS=4, SETS=32, CLEAR_ON_RESET=1 -> busy=1 and req_ready=0 for 32 cycles, then READY. A read of index 31 returns rd_data=0 on all ways.
- Write way 2, index 5, wr_data=64'h1122334455667788, wr_strb=8'hFF; next cycle read index 5 -> rd_valid=1 one cycle later. Way 2 = 64'h1122334455667788, other ways 0.
- Partial write way 2, index 5, wr_data=64'hAAAAAAAAAAAAAAAA, wr_strb=8'h0F; then read -> way 2 = 64'h11223344AAAAAAAA. A following write with wr_strb=8'h00 changes nothing.
- Back-to-back reads of indexes 3, 4, 5 on consecutive cycles -> three consecutive rd_valid pulses with matching data. rd_data is then held for 10 idle cycles while writes occur.
- clear_req asserted with req_valid=1 in READY -> req_ready=0 that cycle, busy for 32 cycles, then a read of index 5 returns 0 on all ways.
- rst_n pulsed low at sweep cycle 10 -> sweep restarts from index 0 and completes 32 cycles after release. Any in-flight rd_valid is suppressed.
